// File: rtl/ext_intr_pkg.sv
// ext_intr_pkg: register map and shared constants for the external interrupt controller.
// The source count is a parameter of ext_intr_ctrl; EXT_INTR_MAX_SRC bounds it.
package ext_intr_pkg;

    localparam logic [3:0] EXT_INTR_PENDING = 4'h0;
    localparam logic [3:0] EXT_INTR_ENABLE  = 4'h4;
    localparam logic [3:0] EXT_INTR_TRIGGER = 4'h8;
    localparam logic [3:0] EXT_INTR_CLAIM   = 4'hC;

    localparam int EXT_INTR_MAX_SRC = 31;
    localparam int EXT_INTR_CLAIM_W = 5;

    // Claim code for a source index: 0 is reserved for "nothing pending".
    function automatic logic [EXT_INTR_CLAIM_W-1:0] ext_intr_claim_code(input int idx);
        return EXT_INTR_CLAIM_W'(idx + 1);
    endfunction

endpackage

// File: rtl/ext_intr_sync_edge.sv
// ext_intr_sync_edge: per-source sampler and rising-edge detector.
// With EXT_INTR_SYNC_EN defined, the request first passes a two-flop synchronizer.
module ext_intr_sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic i_irq,
    output logic o_s,
    output logic o_rise
);

    logic w_s;
    logic r_s_prev;

`ifdef EXT_INTR_SYNC_EN
    logic r_meta;
    logic r_sync;

    // Two-flop synchronizer for a request asynchronous to clk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_irq;
            r_sync <= r_meta;
        end
    end

    assign w_s = r_sync;
`else
    assign w_s = i_irq;
`endif

    // Previous sample, for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s_prev <= 1'b0;
        end else begin
            r_s_prev <= w_s;
        end
    end

    assign o_s    = w_s;
    assign o_rise = w_s & ~r_s_prev;

endmodule

// File: rtl/ext_intr_ctrl.sv
// ext_intr_ctrl: gathers NUM_SRC request lines into the cpu7b ext_intr input.
// Define EXT_INTR_SYNC_EN to synchronize every source (adds two cycles of latency).
module ext_intr_ctrl
    import ext_intr_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               reg_en,
    input  logic               reg_we,
    input  logic [3:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               ext_intr
);

    logic [NUM_SRC-1:0]          w_s;
    logic [NUM_SRC-1:0]          w_rise;
    logic [NUM_SRC-1:0]          w_act;
    logic [NUM_SRC-1:0]          w_claim_oh;
    logic [NUM_SRC-1:0]          w_clr;
    logic [NUM_SRC-1:0]          w_pend_nxt;
    logic [NUM_SRC-1:0]          w_wdata;
    logic [NUM_SRC-1:0]          r_pend;
    logic [NUM_SRC-1:0]          r_en;
    logic [NUM_SRC-1:0]          r_trig;
    logic [3:0]                  w_addr;
    logic                        w_rd;
    logic                        w_wr;
    logic                        w_claim;
    logic                        w_unused;
    logic [EXT_INTR_CLAIM_W-1:0] w_claim_val;
    logic [31:0]                 w_rdata;
    logic [31:0]                 r_rdata;
    logic                        r_intr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            ext_intr_sync_edge u_sync (
                .clk    (clk),
                .resetn (resetn),
                .i_irq  (irq_src[gi]),
                .o_s    (w_s[gi]),
                .o_rise (w_rise[gi])
            );
        end
    endgenerate

    assign w_addr   = {reg_addr[3:2], 2'b00};
    assign w_wdata  = reg_wdata[NUM_SRC-1:0];
    assign w_unused = ^{reg_addr[1:0], reg_wdata[31:NUM_SRC]};
    assign w_rd     = reg_en & ~reg_we;
    assign w_wr     = reg_en & reg_we;
    assign w_claim  = w_rd & (w_addr == EXT_INTR_CLAIM);

    // Lowest-numbered active source wins the claim: isolate its bit.
    assign w_act      = r_pend & r_en;
    assign w_claim_oh = w_act & (~w_act + NUM_SRC'(1'b1));

    // Clears only matter to edge-type bits; level bits follow the sampler.
    assign w_clr      = ({NUM_SRC{w_wr & (w_addr == EXT_INTR_PENDING)}} & w_wdata)
                      | ({NUM_SRC{w_claim}} & w_claim_oh);
    assign w_pend_nxt = (~r_trig & w_s) | (r_trig & (w_rise | (r_pend & ~w_clr)));

    // Encode the one-hot claim winner as 1 + index.
    always_comb begin
        w_claim_val = {EXT_INTR_CLAIM_W{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            w_claim_val = w_claim_val
                        | (w_claim_oh[i] ? ext_intr_claim_code(i) : {EXT_INTR_CLAIM_W{1'b0}});
        end
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        case (w_addr)
            EXT_INTR_PENDING: w_rdata = 32'(r_pend);
            EXT_INTR_ENABLE:  w_rdata = 32'(r_en);
            EXT_INTR_TRIGGER: w_rdata = 32'(r_trig);
            EXT_INTR_CLAIM:   w_rdata = 32'(w_claim_val);
            default:          w_rdata = 32'h0000_0000;
        endcase
    end

    // Control registers and pending state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend <= {NUM_SRC{1'b0}};
            r_en   <= {NUM_SRC{1'b0}};
            r_trig <= {NUM_SRC{1'b0}};
        end else begin
            r_pend <= w_pend_nxt;
            if (w_wr && (w_addr == EXT_INTR_ENABLE)) begin
                r_en <= w_wdata;
            end
            if (w_wr && (w_addr == EXT_INTR_TRIGGER)) begin
                r_trig <= w_wdata;
            end
        end
    end

    // Registered read data and interrupt output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= 32'h0000_0000;
            r_intr  <= 1'b0;
        end else begin
            if (w_rd) begin
                r_rdata <= w_rdata;
            end
            r_intr <= |w_act;
        end
    end

    assign reg_rdata = r_rdata;
    assign ext_intr  = r_intr;

endmodule

// File: tb/tb_ext_intr_ctrl.sv
// Scoreboard bench for ext_intr_ctrl: a cycle-level reference model queues expected
// ext_intr and read data; a monitor compares them one time unit after each rising edge.
module tb_ext_intr_ctrl;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic [N-1:0]  irq_src;
    logic          reg_en;
    logic          reg_we;
    logic [3:0]    reg_addr;
    logic [31:0]   reg_wdata;
    logic [31:0]   reg_rdata;
    logic          ext_intr;

    always #5 clk = ~clk;

    ext_intr_ctrl #(.NUM_SRC(N)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .irq_src   (irq_src),
        .reg_en    (reg_en),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .ext_intr  (ext_intr)
    );

`ifdef EXT_INTR_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    int errors = 0;
    int checks = 0;

    logic        intr_q[$];
    logic [31:0] rd_q[$];
    int          rd_a_q[$];
    string       reg_name[4] = '{"PENDING", "ENABLE", "TRIGGER", "CLAIM"};

    // Reference model state: per-source pending/enable/trigger and sampler history.
    logic [N-1:0] m_pend, m_en, m_trig, m_prev;
    logic [N-1:0] m_dly[2];

    initial begin : model
        logic [N-1:0] s, rise, clr;
        logic [31:0]  rv;
        int           word;
        int           claim;
        m_pend = '0; m_en = '0; m_trig = '0; m_prev = '0;
        m_dly[0] = '0; m_dly[1] = '0;
        forever begin
            @(posedge clk);
            if (!resetn) begin
                m_pend = '0; m_en = '0; m_trig = '0; m_prev = '0;
                m_dly[0] = '0; m_dly[1] = '0;
                intr_q.push_back(1'b0);
            end else begin
                if (SYNC_LAT == 2) begin
                    s = m_dly[1];
                    m_dly[1] = m_dly[0];
                    m_dly[0] = irq_src;
                end else begin
                    s = irq_src;
                end
                rise = s & ~m_prev;
                intr_q.push_back(|(m_pend & m_en));
                claim = 0;
                for (int i = N - 1; i >= 0; i--) begin
                    if (m_pend[i] && m_en[i]) claim = i + 1;
                end
                word = int'(reg_addr[3:2]);
                clr = '0;
                if (reg_en && !reg_we) begin
                    case (word)
                        0:       rv = 32'(m_pend);
                        1:       rv = 32'(m_en);
                        2:       rv = 32'(m_trig);
                        default: rv = claim;
                    endcase
                    rd_q.push_back(rv);
                    rd_a_q.push_back(word);
                    if (word == 3 && claim != 0) clr[claim-1] = 1'b1;
                end
                if (reg_en && reg_we && word == 0) clr = clr | reg_wdata[N-1:0];
                for (int i = 0; i < N; i++) begin
                    if (m_trig[i]) m_pend[i] = rise[i] | (m_pend[i] & ~clr[i]);
                    else           m_pend[i] = s[i];
                end
                if (reg_en && reg_we && word == 1) m_en = reg_wdata[N-1:0];
                if (reg_en && reg_we && word == 2) m_trig = reg_wdata[N-1:0];
                m_prev = s;
            end
        end
    end

    // Monitor: pop every expectation queued at this edge and compare.
    initial begin : monitor
        logic        e;
        logic [31:0] v;
        int          a;
        forever begin
            @(posedge clk);
            #1;
            while (intr_q.size() > 0) begin
                e = intr_q.pop_front();
                checks++;
                if (ext_intr !== e) begin
                    errors++;
                    $display("FAIL ext_intr @%0t: got %0b expected %0b", $time, ext_intr, e);
                end
            end
            while (rd_q.size() > 0) begin
                v = rd_q.pop_front();
                a = rd_a_q.pop_front();
                checks++;
                if (reg_rdata !== v) begin
                    errors++;
                    $display("FAIL read_%s @%0t: got 0x%08h expected 0x%08h",
                             reg_name[a], $time, reg_rdata, v);
                end
            end
        end
    end

    logic [N-1:0] cur_irq;

    task automatic cyc(input logic en, input logic we, input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        irq_src   = cur_irq;
        reg_en    = en;
        reg_we    = we;
        reg_addr  = a;
        reg_wdata = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [3:0] a);
        cyc(1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic pulse(input logic [N-1:0] m);
        cur_irq = m;
        idle(1);
        cur_irq = '0;
    endtask

    initial begin : stim
        resetn = 1'b0; cur_irq = 8'hFF; irq_src = 8'hFF;
        reg_en = 1'b0; reg_we = 1'b0; reg_addr = 4'h0; reg_wdata = 32'h0;

        // Reset with all sources high, then release with sources low.
        idle(4);
        cur_irq = '0;
        @(negedge clk); resetn = 1'b1; irq_src = '0;
        idle(3);
        rd(4'h0); rd(4'h4); rd(4'h8); rd(4'hC);

        // Edge source 3: one-cycle pulse, then claim.
        wr(4'h8, 32'h08); wr(4'h4, 32'h08);
        pulse(8'h08);
        idle(5);
        rd(4'h0); rd(4'hC); idle(3); rd(4'h0);

        // Level source 0 held for 60 ns; W1C must not affect it.
        wr(4'h8, 32'h00); wr(4'h4, 32'h01);
        cur_irq = 8'h01;
        idle(3); wr(4'h0, 32'h01); rd(4'h0); idle(1);
        cur_irq = '0;
        idle(SYNC_LAT + 3); rd(4'h0);

        // Priority: sources 5 and 2 edge-pending.
        wr(4'h8, 32'h24); wr(4'h4, 32'h24);
        pulse(8'h24);
        idle(SYNC_LAT + 2);
        rd(4'hC); rd(4'hC); rd(4'hC); rd(4'h0); idle(2);

        // Mask: source 1 pending but disabled, then enabled.
        wr(4'h4, 32'h00); wr(4'h8, 32'h02);
        pulse(8'h02);
        idle(SYNC_LAT + 3);
        rd(4'h0); wr(4'h4, 32'h02); idle(2);
        wr(4'h0, 32'h02); idle(2);

        // Collision: rising edge on source 4 in the W1C cycle (unaligned address too).
        wr(4'h8, 32'h10); wr(4'h4, 32'h10);
        cur_irq = 8'h10;
        for (int i = 0; i < SYNC_LAT; i++) idle(1);
        wr(4'h1, 32'h10);
        cur_irq = '0;
        rd(4'h2); rd(4'h0); idle(2);

        // Reset mid-operation with a pending edge and a live level source.
        wr(4'h8, 32'h0F); wr(4'h4, 32'hFF);
        pulse(8'h03);
        cur_irq = 8'h80;
        idle(1);
        @(negedge clk); resetn = 1'b0; reg_en = 1'b0;
        idle(2);
        cur_irq = '0;
        @(negedge clk); resetn = 1'b1; irq_src = '0;
        idle(SYNC_LAT + 2);
        rd(4'h0); rd(4'h4); rd(4'h8);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) cur_irq = cur_irq ^ N'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                @(negedge clk); resetn = 1'b0; reg_en = 1'b0;
                idle(1);
                @(negedge clk); resetn = 1'b1; reg_en = 1'b0;
            end else begin
                cyc(1'($urandom), 1'($urandom), 4'($urandom), $urandom);
            end
        end

        idle(3);
        @(posedge clk); #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ext_intr_ctrl.md
# ext_intr_ctrl

External interrupt controller that gathers up to `NUM_SRC` asynchronous interrupt request lines from the board and peripherals, and drives the single `ext_intr` input of the cpu7b core. It sits beside the CPU in `top` and is the source side of the `ext_intr` line that top-level benches currently force by hand. Software programs it through a small word-addressed register port with per-source enable, trigger type, write-1-to-clear pending bits and a claim register.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources, legal range 1..31.
- `clk` input 1: single clock.
- `resetn` input 1: reset, asynchronous, active-low.
- `irq_src` input NUM_SRC: raw request lines, asynchronous to `clk`, active-high.
- `reg_en` input 1: register access strobe, one access per cycle.
- `reg_we` input 1: 1 = write, 0 = read.
- `reg_addr` input 4: byte address; bits [1:0] ignored.
- `reg_wdata` input 32: write data.
- `reg_rdata` output 32: read data, registered.
- `ext_intr` output 1: interrupt request to the CPU, registered, level-high.

## Operation
- Each source goes through a sampler that produces signal `s[i]` and a registered `s_prev[i]`; rising edge = `s & ~s_prev`.
- Registers (offset; bits above NUM_SRC read 0):
  - 0x0 PENDING: read returns pending; write-1-to-clear, edge-type bits only.
  - 0x4 ENABLE: read/write mask.
  - 0x8 TRIGGER: read/write; 1 = edge, 0 = level.
  - 0xC CLAIM: read-only. Returns 1 + index of the lowest-numbered pending&enabled source, or 0 if none. If the claimed source is edge-type, its pending bit clears in the same cycle. Writes are ignored.
- Level source: the pending bit equals `s[i]` each cycle. W1C and claim have no effect.
- Edge source: the pending bit sets on a rising edge and holds until W1C or claim. A set in the same cycle as a clear wins.
- Changing TRIGGER from level to edge keeps the current pending value. Changing from edge to level makes the bit follow `s` from the next cycle.
- `ext_intr` is the registered value of `|(PENDING & ENABLE)`.
- Unmapped addresses: reads return 0, writes are ignored.

## Timing
- Reset values: all registers, sampler flops, `reg_rdata` and `ext_intr` are 0. Reset asserted mid-operation clears everything asynchronously, including any in-flight edge.
- Reads: `reg_rdata` is valid the cycle after `reg_en & ~reg_we` and holds until the next read.
- Writes and claim side effects take effect at the clock edge of the access cycle.
- A claim read returns pre-clear state. The resulting pending change reaches `ext_intr` one cycle later.
- Latency with the sync macro: `irq_src` high before edge N → pending at edge N+2 → `ext_intr` at edge N+3.
- Latency without the macro: pending at edge N → `ext_intr` at edge N+1.

## Configuration
- `EXT_INTR_SYNC_EN` defined: `s[i]` is the output of a two-flop synchronizer, for sources asynchronous to `clk`.
- `EXT_INTR_SYNC_EN` undefined: `s[i]` = `irq_src[i]` directly, for synchronous sources. Latency drops by 2 cycles. Edge detect and all register behaviour are unchanged.

## Structure
- Package `ext_intr_pkg`: register offsets (`EXT_INTR_PENDING`, `_ENABLE`, `_TRIGGER`, `_CLAIM`), `EXT_INTR_MAX_SRC = 31`, claim width constant.
- Sub-module `ext_intr_sync_edge`: one source's optional synchronizer, `s_prev` flop and rise output. Instantiated NUM_SRC times in a generate loop.
- Top module: pending/enable/trigger registers, priority encoder for claim, register decode and read mux.

## Test plan
- Reset: hold `resetn`=0 with `irq_src`=0xFF → `ext_intr`=0 and all register reads 0 after release.
- Edge source 3 with TRIGGER=0x08 and ENABLE=0x08: pulse `irq_src[3]` high for 1 clock period → PENDING=0x08 and `ext_intr`=1 at the specified latency; claim reads 4; `ext_intr`=0 two cycles after the claim access.
- Level source 0 with ENABLE=0x01 and TRIGGER=0: hold `irq_src[0]` high for 60 ns → `ext_intr` high for the duration; write PENDING=0x01 → no effect; after the source drops, `ext_intr`=0.
- Priority: sources 5 and 2 edge-pending, both enabled → claim returns 3, then 6, then 0; PENDING then reads 0.
- Mask: source 1 pending with ENABLE=0 → `ext_intr`=0; write ENABLE=0x02 → `ext_intr`=1 at edge+1.
- Collision: a rising edge on source 4 in the same cycle as a W1C of 0x10 → PENDING bit 4 remains 1.
